// File: rtl/mem_spi_pkg.sv
// Shared opcodes and FSM state encoding for the SPI/QSPI flash responder.
package mem_spi_pkg;

   localparam logic [7:0] OP_WREN  = 8'h06;
   localparam logic [7:0] OP_WRDI  = 8'h04;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_QREAD = 8'h6B;
   localparam logic [7:0] OP_PP    = 8'h02;
   localparam logic [7:0] OP_QPP   = 8'h32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_RD_DATA,
      ST_WR_DATA,
      ST_STATUS,
      ST_IGNORE
   } state_e;

endpackage

// File: rtl/mem_spi_edge_sync.sv
// Registers SCLK and CS_n and turns them into single-cycle edge strobes.
// The first register stage is the sampled level; the second holds the
// previous sample so edges are detected between the two.
module mem_spi_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic in_sclk_i,
   input  logic in_cs_n_i,
   output logic rise_o,
   output logic fall_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic cs_n_o
);

   logic sclk_s_q;
   logic sclk_p_q;
   logic cs_s_q;
   logic cs_p_q;

   // Sample SCLK/CS_n once, then keep the previous sample for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_s_q <= 1'b0;
         sclk_p_q <= 1'b0;
         cs_s_q   <= 1'b1;
         cs_p_q   <= 1'b1;
      end else begin
         sclk_s_q <= in_sclk_i;
         sclk_p_q <= sclk_s_q;
         cs_s_q   <= in_cs_n_i;
         cs_p_q   <= cs_s_q;
      end
   end

   assign rise_o    =  sclk_s_q & ~sclk_p_q;
   assign fall_o    = ~sclk_s_q &  sclk_p_q;
   assign cs_fall_o = ~cs_s_q   &  cs_p_q;
   assign cs_rise_o =  cs_s_q   & ~cs_p_q;
   assign cs_n_o    =  cs_s_q;

endmodule

// File: rtl/mem_spi_flash_responder.sv
// SPI/QSPI NOR-flash responder: decodes opcode/address/dummy/data phases
// (mode 0, MSB first) and serves reads from or programs an internal byte
// array. Inputs are sampled on SCLK rise, outputs change on SCLK fall.
module mem_spi_flash_responder
   import mem_spi_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int BUSY_CYCLES = 64,
   parameter int DUMMY_CLKS  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_cs_n,
   input  logic       in_sclk,
   input  logic [3:0] in_io,
   output logic [3:0] out_io,
   output logic [3:0] out_io_oe,
   output logic       out_busy
);

   localparam int BCW = $clog2(BUSY_CYCLES + 1);
   localparam int DCW = $clog2(DUMMY_CLKS + 1);
   localparam logic [BCW-1:0]    BUSY_LOAD  = BCW'(BUSY_CYCLES);
   localparam logic [DCW-1:0]    DUMMY_LAST = DCW'(DUMMY_CLKS - 1);
   // Low 8 address bits form the in-page offset for programming.
   localparam logic [ADDR_W-1:0] PAGE_MASK  = ADDR_W'(8'hFF);

   logic rise, fall, cs_fall, cs_rise, cs_n_s;
   logic rise_v, fall_v;

   mem_spi_edge_sync u_edge_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_sclk_i (in_sclk),
      .in_cs_n_i (in_cs_n),
      .rise_o    (rise),
      .fall_o    (fall),
      .cs_fall_o (cs_fall),
      .cs_rise_o (cs_rise),
      .cs_n_o    (cs_n_s)
   );

   // SCLK activity only counts while the chip is selected.
   assign rise_v = rise & ~cs_n_s;
   assign fall_v = fall & ~cs_n_s;

   logic [7:0]        mem [0:(1<<ADDR_W)-1];

   state_e            state_q;
   logic [7:0]        opcode_q;
   logic [7:0]        in_sr_q;
   logic [7:0]        out_sr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        bit_cnt_q;
   logic              nib_q;
   logic [4:0]        addr_cnt_q;
   logic [DCW-1:0]    dummy_cnt_q;
   logic              quad_q;
   logic              wel_q;
   logic              busy_q;
   logic [BCW-1:0]    busy_cnt_q;
   logic              wrote_q;
   logic              wren_pend_q;
   logic              wrdi_pend_q;
   logic [3:0]        out_io_q;
   logic [3:0]        oe_q;

   logic [7:0]        cmd_byte;
   logic [ADDR_W-1:0] addr_shift;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] addr_page_inc;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_byte;
   logic [7:0]        wr_byte;
   logic              wr_en;

   assign cmd_byte      = {in_sr_q[6:0], in_io[0]};
   assign addr_shift    = {addr_q[ADDR_W-2:0], in_io[0]};
   assign addr_inc      = addr_q + 1'b1;
   assign addr_page_inc = (addr_q & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
   assign wr_byte       = quad_q ? {in_sr_q[3:0], in_io} : {in_sr_q[6:0], in_io[0]};
   assign wr_en         = (state_q == ST_WR_DATA) && rise_v &&
                          (quad_q ? nib_q : (bit_cnt_q == 3'd7));

   // Pick the byte address the FSM will load next: the freshly completed
   // address, the held address after dummies, or the following byte.
   always_comb begin
      rd_addr = addr_q;
      if (state_q == ST_ADDR) begin
         rd_addr = addr_shift;
      end else if (state_q == ST_RD_DATA) begin
         rd_addr = addr_inc;
      end
   end

   assign rd_byte = mem[rd_addr];

   // Byte array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr_q] <= wr_byte;
      end
   end

   // Protocol FSM with registered IO drive, WEL and BUSY status.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         opcode_q    <= '0;
         in_sr_q     <= '0;
         out_sr_q    <= '0;
         addr_q      <= '0;
         bit_cnt_q   <= '0;
         nib_q       <= 1'b0;
         addr_cnt_q  <= '0;
         dummy_cnt_q <= '0;
         quad_q      <= 1'b0;
         wel_q       <= 1'b0;
         busy_q      <= 1'b0;
         busy_cnt_q  <= '0;
         wrote_q     <= 1'b0;
         wren_pend_q <= 1'b0;
         wrdi_pend_q <= 1'b0;
         out_io_q    <= '0;
         oe_q        <= '0;
      end else begin
         if (busy_q) begin
            if (busy_cnt_q == '0) begin
               busy_q <= 1'b0;
               wel_q  <= 1'b0;
            end else begin
               busy_cnt_q <= busy_cnt_q - 1'b1;
            end
         end

         if (cs_rise) begin
            state_q   <= ST_IDLE;
            oe_q      <= '0;
            out_io_q  <= '0;
            bit_cnt_q <= '0;
            nib_q     <= 1'b0;
            if (state_q == ST_WR_DATA && wrote_q) begin
               busy_q     <= 1'b1;
               busy_cnt_q <= BUSY_LOAD;
            end
            // WREN/WRDI take effect only when no clock followed the opcode.
            if (state_q == ST_IGNORE && wren_pend_q) wel_q <= 1'b1;
            if (state_q == ST_IGNORE && wrdi_pend_q) wel_q <= 1'b0;
            wren_pend_q <= 1'b0;
            wrdi_pend_q <= 1'b0;
            wrote_q     <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (cs_fall) begin
                     state_q   <= ST_CMD;
                     bit_cnt_q <= '0;
                     nib_q     <= 1'b0;
                     wrote_q   <= 1'b0;
                  end
               end

               ST_CMD: begin
                  if (rise_v) begin
                     in_sr_q   <= cmd_byte;
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == 3'd7) begin
                        opcode_q   <= cmd_byte;
                        addr_cnt_q <= '0;
                        state_q    <= ST_IGNORE;
                        if (!busy_q || cmd_byte == OP_RDSR) begin
                           case (cmd_byte)
                              OP_WREN: wren_pend_q <= 1'b1;
                              OP_WRDI: wrdi_pend_q <= 1'b1;
                              OP_RDSR: begin
                                 state_q  <= ST_STATUS;
                                 quad_q   <= 1'b0;
                                 out_sr_q <= {6'b0, wel_q, busy_q};
                              end
                              OP_READ: begin
                                 state_q <= ST_ADDR;
                                 quad_q  <= 1'b0;
                              end
                              OP_QREAD: begin
                                 state_q <= ST_ADDR;
                                 quad_q  <= 1'b1;
                              end
                              OP_PP: begin
                                 if (wel_q) state_q <= ST_ADDR;
                                 quad_q <= 1'b0;
                              end
                              OP_QPP: begin
                                 if (wel_q) state_q <= ST_ADDR;
                                 quad_q <= 1'b1;
                              end
                              default: state_q <= ST_IGNORE;
                           endcase
                        end
                     end
                  end
               end

               ST_ADDR: begin
                  if (rise_v) begin
                     addr_q     <= addr_shift;
                     addr_cnt_q <= addr_cnt_q + 1'b1;
                     if (addr_cnt_q == 5'd23) begin
                        bit_cnt_q   <= '0;
                        nib_q       <= 1'b0;
                        dummy_cnt_q <= '0;
                        case (opcode_q)
                           OP_READ: begin
                              state_q  <= ST_RD_DATA;
                              out_sr_q <= rd_byte;
                           end
                           OP_QREAD:      state_q <= ST_DUMMY;
                           OP_PP, OP_QPP: state_q <= ST_WR_DATA;
                           default:       state_q <= ST_IGNORE;
                        endcase
                     end
                  end
               end

               ST_DUMMY: begin
                  if (rise_v) begin
                     dummy_cnt_q <= dummy_cnt_q + 1'b1;
                     if (dummy_cnt_q == DUMMY_LAST) begin
                        state_q  <= ST_RD_DATA;
                        out_sr_q <= rd_byte;
                     end
                  end
               end

               ST_RD_DATA: begin
                  if (fall_v) begin
                     if (quad_q) begin
                        oe_q     <= 4'b1111;
                        out_io_q <= out_sr_q[7:4];
                        nib_q    <= ~nib_q;
                        if (nib_q) begin
                           addr_q   <= addr_inc;
                           out_sr_q <= rd_byte;
                        end else begin
                           out_sr_q <= {out_sr_q[3:0], 4'b0000};
                        end
                     end else begin
                        oe_q      <= 4'b0010;
                        out_io_q  <= {2'b00, out_sr_q[7], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                           addr_q   <= addr_inc;
                           out_sr_q <= rd_byte;
                        end else begin
                           out_sr_q <= {out_sr_q[6:0], 1'b0};
                        end
                     end
                  end
               end

               ST_WR_DATA: begin
                  if (rise_v) begin
                     if (quad_q) begin
                        in_sr_q <= {in_sr_q[3:0], in_io};
                        nib_q   <= ~nib_q;
                        if (nib_q) begin
                           addr_q  <= addr_page_inc;
                           wrote_q <= 1'b1;
                        end
                     end else begin
                        in_sr_q   <= {in_sr_q[6:0], in_io[0]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                           addr_q  <= addr_page_inc;
                           wrote_q <= 1'b1;
                        end
                     end
                  end
               end

               ST_STATUS: begin
                  if (fall_v) begin
                     oe_q      <= 4'b0010;
                     out_io_q  <= {2'b00, out_sr_q[7], 1'b0};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == 3'd7) begin
                        out_sr_q <= {6'b0, wel_q, busy_q};
                     end else begin
                        out_sr_q <= {out_sr_q[6:0], 1'b0};
                     end
                  end
               end

               ST_IGNORE: begin
                  // Any clock after a WREN/WRDI opcode cancels its effect.
                  if (rise_v) begin
                     wren_pend_q <= 1'b0;
                     wrdi_pend_q <= 1'b0;
                  end
               end

               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign out_io    = out_io_q;
   assign out_io_oe = oe_q;
   assign out_busy  = busy_q;

endmodule

// File: tb/tb_mem_spi_flash_responder.sv
// Directed bench for the SPI/QSPI flash responder.
module tb_mem_spi_flash_responder;

   localparam int BUSY_CYCLES = 64;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_cs_n;
   logic       in_sclk;
   logic [3:0] in_io;
   logic [3:0] out_io;
   logic [3:0] out_io_oe;
   logic       out_busy;

   int         tests = 0;
   int         fails = 0;
   int         half  = 4;
   logic [3:0] oe_or;

   // clock / reset block
   always #5 clk = ~clk;

   mem_spi_flash_responder #(
      .ADDR_W      (10),
      .BUSY_CYCLES (BUSY_CYCLES),
      .DUMMY_CLKS  (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_cs_n   (in_cs_n),
      .in_sclk   (in_sclk),
      .in_io     (in_io),
      .out_io    (out_io),
      .out_io_oe (out_io_oe),
      .out_busy  (out_busy)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic spi_clk(input logic [3:0] io, output logic [3:0] so);
      repeat (half) @(negedge clk);
      so    = out_io;
      oe_or = oe_or | out_io_oe;
      in_io   = io;
      in_sclk = 1'b1;
      repeat (half) @(negedge clk);
      oe_or   = oe_or | out_io_oe;
      in_sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [3:0] so;
      for (int i = 7; i >= 0; i--) spi_clk({3'b000, b[i]}, so);
   endtask

   task automatic send_qbyte(input logic [7:0] b);
      logic [3:0] so;
      spi_clk(b[7:4], so);
      spi_clk(b[3:0], so);
   endtask

   task automatic send_addr(input logic [23:0] a);
      send_byte(a[23:16]);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
   endtask

   task automatic recv_byte(output logic [7:0] b);
      logic [3:0] so;
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         spi_clk(4'h0, so);
         b = {b[6:0], so[1]};
      end
   endtask

   task automatic cs_begin();
      @(negedge clk);
      in_cs_n = 1'b0;
   endtask

   task automatic cs_end();
      repeat (2) @(negedge clk);
      in_cs_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic cmd_only(input logic [7:0] op);
      cs_begin();
      send_byte(op);
      cs_end();
   endtask

   task automatic read_bytes(input logic [23:0] a, output logic [7:0] d0, output logic [7:0] d1);
      cs_begin();
      send_byte(8'h03);
      send_addr(a);
      recv_byte(d0);
      recv_byte(d1);
      cs_end();
   endtask

   task automatic read_status(output logic [7:0] s);
      cs_begin();
      send_byte(8'h05);
      recv_byte(s);
      cs_end();
   endtask

   // Raise CS after a program, report BUSY 3 clk later and total BUSY length.
   task automatic end_prog(output int n, output logic busy3);
      repeat (2) @(negedge clk);
      in_cs_n = 1'b1;
      repeat (3) @(negedge clk);
      busy3 = out_busy;
      n = 3;
      while (out_busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_not_busy(output int n);
      n = 0;
      while (out_busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; in_cs_n = 1'b1; in_sclk = 1'b0; in_io = 4'h0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++; if (out_io !== 4'h0) begin fails++; $display("FAIL reset_io: got %h expected 0", out_io); end
      tests++; if (out_io_oe !== 4'h0) begin fails++; $display("FAIL reset_oe: got %h expected 0", out_io_oe); end
      tests++; if (out_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", out_busy); end
   endtask

   task automatic test_pp_read();
      logic [7:0] d0, d1, s;
      logic       b3;
      int         n;
      logic [3:0] oe;
      cmd_only(8'h06);
      cs_begin();
      send_byte(8'h02);
      send_addr(24'h000010);
      send_byte(8'hA5);
      send_byte(8'h3C);
      end_prog(n, b3);
      tests++; if (b3 !== 1'b1) begin fails++; $display("FAIL pp_busy_set: got %b expected 1", b3); end
      tests++; if (n != BUSY_CYCLES + 3) begin fails++; $display("FAIL pp_busy_len: got %0d expected %0d", n, BUSY_CYCLES + 3); end
      cs_begin();
      send_byte(8'h03);
      send_addr(24'h000010);
      recv_byte(d0);
      recv_byte(d1);
      oe = out_io_oe;
      cs_end();
      tests++; if (d0 !== 8'hA5) begin fails++; $display("FAIL read_b0: got %h expected a5", d0); end
      tests++; if (d1 !== 8'h3C) begin fails++; $display("FAIL read_b1: got %h expected 3c", d1); end
      tests++; if (oe !== 4'b0010) begin fails++; $display("FAIL read_oe: got %b expected 0010", oe); end
      tests++; if (out_io_oe !== 4'h0) begin fails++; $display("FAIL oe_release: got %b expected 0000", out_io_oe); end
      read_status(s);
      tests++; if (s !== 8'h00) begin fails++; $display("FAIL rdsr_after_pp: got %h expected 00", s); end
   endtask

   task automatic test_pp_no_wel();
      logic [7:0] d0, d1;
      cs_begin();
      send_byte(8'h02);
      send_addr(24'h000010);
      send_byte(8'h00);
      cs_end();
      tests++; if (out_busy !== 1'b0) begin fails++; $display("FAIL nowel_busy: got %b expected 0", out_busy); end
      read_bytes(24'h000010, d0, d1);
      tests++; if (d0 !== 8'hA5) begin fails++; $display("FAIL nowel_mem: got %h expected a5", d0); end
   endtask

   task automatic test_qpp_status();
      logic [7:0] s0, s1;
      int         n;
      cmd_only(8'h06);
      cs_begin();
      send_byte(8'h05);
      recv_byte(s0);
      recv_byte(s1);
      cs_end();
      tests++; if ({s0, s1} !== 16'h0202) begin fails++; $display("FAIL rdsr_wel_repeat: got %h expected 0202", {s0, s1}); end
      cs_begin();
      send_byte(8'h32);
      send_addr(24'h000020);
      send_qbyte(8'h12);
      send_qbyte(8'h34);
      cs_end();
      half = 2;
      read_status(s0);
      half = 4;
      tests++; if (s0 !== 8'h03) begin fails++; $display("FAIL rdsr_busy: got %h expected 03", s0); end
      wait_not_busy(n);
      tests++; if (n >= 1000) begin fails++; $display("FAIL busy_timeout: got %0d cycles expected < 1000", n); end
      read_status(s0);
      tests++; if (s0 !== 8'h00) begin fails++; $display("FAIL rdsr_done: got %h expected 00", s0); end
   endtask

   task automatic test_qread();
      logic [3:0]  so;
      logic [15:0] nibs;
      logic [3:0]  oe;
      cs_begin();
      send_byte(8'h6B);
      send_addr(24'h000020);
      oe_or = 4'h0;
      for (int i = 0; i < 8; i++) spi_clk(4'h0, so);
      tests++; if (oe_or !== 4'h0) begin fails++; $display("FAIL qread_dummy_oe: got %b expected 0000", oe_or); end
      nibs = 16'h0;
      for (int i = 0; i < 4; i++) begin
         spi_clk(4'h0, so);
         nibs = {nibs[11:0], so};
         if (i == 0) oe = out_io_oe;
      end
      cs_end();
      tests++; if (oe !== 4'b1111) begin fails++; $display("FAIL qread_oe: got %b expected 1111", oe); end
      tests++; if (nibs !== 16'h1234) begin fails++; $display("FAIL qread_data: got %h expected 1234", nibs); end
   endtask

   task automatic test_wrap();
      logic [7:0] d0, d1;
      logic       b3;
      int         n;
      cmd_only(8'h06);
      cs_begin(); send_byte(8'h02); send_addr(24'h0003FF); send_byte(8'h77); end_prog(n, b3);
      cmd_only(8'h06);
      cs_begin(); send_byte(8'h02); send_addr(24'h0000FF); send_byte(8'h11); send_byte(8'h22); end_prog(n, b3);
      read_bytes(24'h0000FF, d0, d1);
      tests++; if (d0 !== 8'h11) begin fails++; $display("FAIL page_ff: got %h expected 11", d0); end
      read_bytes(24'h000000, d0, d1);
      tests++; if (d0 !== 8'h22) begin fails++; $display("FAIL page_wrap: got %h expected 22", d0); end
      read_bytes(24'h0003FF, d0, d1);
      tests++; if ({d0, d1} !== 16'h7722) begin fails++; $display("FAIL array_wrap: got %h expected 7722", {d0, d1}); end
   endtask

   task automatic test_abort();
      logic [7:0] d0, d1, s;
      logic [3:0] so;
      logic       b3;
      int         n;
      cmd_only(8'h06);
      cs_begin(); send_byte(8'h02); send_addr(24'h000030); send_byte(8'h5A); end_prog(n, b3);
      cmd_only(8'h06);
      cs_begin();
      send_byte(8'h02);
      send_addr(24'h000030);
      for (int i = 0; i < 5; i++) spi_clk(4'h1, so);
      cs_end();
      tests++; if (out_busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", out_busy); end
      read_status(s);
      tests++; if (s !== 8'h02) begin fails++; $display("FAIL abort_wel: got %h expected 02", s); end
      read_bytes(24'h000030, d0, d1);
      tests++; if (d0 !== 8'h5A) begin fails++; $display("FAIL abort_mem: got %h expected 5a", d0); end
      cmd_only(8'h04);
      read_status(s);
      tests++; if (s !== 8'h00) begin fails++; $display("FAIL wrdi: got %h expected 00", s); end
   endtask

   task automatic test_unknown();
      logic [3:0] so;
      oe_or = 4'h0;
      cs_begin();
      send_byte(8'h9F);
      for (int i = 0; i < 16; i++) spi_clk(4'h0, so);
      cs_end();
      tests++; if (oe_or !== 4'h0) begin fails++; $display("FAIL unknown_oe: got %b expected 0000", oe_or); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] so;
      logic [7:0] s;
      cmd_only(8'h06);
      cs_begin();
      send_byte(8'h03);
      send_addr(24'h000010);
      for (int i = 0; i < 4; i++) spi_clk(4'h0, so);
      tests++; if (out_io_oe !== 4'b0010) begin fails++; $display("FAIL mid_oe_active: got %b expected 0010", out_io_oe); end
      rst_n = 1'b0;
      in_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++; if ({out_io, out_io_oe, out_busy} !== 9'h0) begin fails++; $display("FAIL mid_reset_outs: got %h expected 000", {out_io, out_io_oe, out_busy}); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      read_status(s);
      tests++; if (s !== 8'h00) begin fails++; $display("FAIL mid_reset_wel: got %h expected 00", s); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      oe_or = 4'h0;
      test_reset();
      test_pp_read();
      test_pp_no_wel();
      test_qpp_status();
      test_qread();
      test_wrap();
      test_abort();
      test_unknown();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
